// File: rtl/pipe_pkg.sv
// Shared constants, types and sizing helpers for the pipe_reg pipeline register.
package pipe_pkg;

  localparam int unsigned DEFAULT_WIDTH = 64;

  typedef logic [DEFAULT_WIDTH-1:0] word_t;

  // Bits needed to count 0..depth valid stages.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_flopenrc.sv
// flopenrc: one pipeline stage with enable, synchronous clear and
// asynchronous active-low reset to RESET_VAL.
module flopenrc #(
  parameter int unsigned       WIDTH     = 65,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  // Clear outranks enable so a bubble can be forced while the pipe advances.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= RESET_VAL;
    end else if (clr_i) begin
      q_q <= RESET_VAL;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_reg.sv
// pipe_reg: DEPTH-stage enabled pipeline register with per-stage valid bits and
// registered occupancy. Define PIPE_REG_FLUSH_EN to enable the synchronous flush.
module pipe_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              d,
  output logic [WIDTH-1:0]              q,
  output logic                          q_valid,
  output logic [occ_width(DEPTH)-1:0]   occupancy
);

  localparam int unsigned OW = occ_width(DEPTH);
  localparam int unsigned SW = WIDTH + 1;

  if (DEPTH < 1) begin : g_depth_check
    $error("pipe_reg: DEPTH must be at least 1");
  end

  logic clr;

`ifdef PIPE_REG_FLUSH_EN
  assign clr = flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign clr          = 1'b0;
`endif

  // Each stage carries {valid, data}; data shifts whatever its valid bit says.
  logic [SW-1:0] stage_q [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [SW-1:0] stage_d;

    if (i == 0) begin : g_head
      assign stage_d = {in_valid, d};
    end else begin : g_body
      assign stage_d = stage_q[i-1];
    end

    flopenrc #(
      .WIDTH     (SW),
      .RESET_VAL ({1'b0, RESET_VAL})
    ) u_stage (
      .clk_i  (clk),
      .rst_ni (reset),
      .en_i   (en),
      .clr_i  (clr),
      .d_i    (stage_d),
      .q_o    (stage_q[i])
    );
  end

  logic [SW-1:0] last_stage;

  assign last_stage = stage_q[DEPTH-1];
  assign q          = last_stage[WIDTH-1:0];
  assign q_valid    = last_stage[WIDTH];

  logic [OW-1:0] occ_q;
  logic [OW-1:0] occ_d;

  // Net change is +1 when a valid enters without one leaving, -1 for the reverse.
  always_comb begin
    occ_d = occ_q;
    if (clr) begin
      occ_d = '0;
    end else if (en && (in_valid != q_valid)) begin
      occ_d = in_valid ? occ_q + 1'b1 : occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule
